// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//
// Serial-in / parallel-out frame deserializer with a ready/valid output
// handshake. A frame starts on a bit qualified by both bit_valid and
// frame_start. It is WIDTH data bits long, plus one even-parity bit when the
// SIPO_PARITY_EN macro is defined. Bit order is chosen per frame by shift_dir,
// which is sampled together with bit 0. A word that completes while the
// previous word is still pending and not being accepted is dropped, and the
// sticky overrun flag is set.
//
// Configuration macro:
//   SIPO_PARITY_EN  defined   : WIDTH data bits + 1 even-parity bit per frame,
//                               parity_err reports the check result.
//                   undefined : WIDTH data bits per frame, parity_err is 0.
//
// Ports:
//   clk          in   clock; all state changes on the rising edge
//   reset        in   asynchronous, active-high reset
//   serial_in    in   serial data bit, sampled only when bit_valid=1
//   bit_valid    in   qualifies serial_in for one cycle
//   frame_start  in   marks serial_in as bit 0 of a new frame (needs bit_valid)
//   shift_dir    in   0 = LSB first, 1 = MSB first; sampled with bit 0
//   out_ready    in   downstream accepts par_out while out_valid=1
//   par_out      out  [WIDTH] assembled word
//   out_valid    out  par_out holds an unconsumed word
//   busy         out  frame in progress
//   overrun      out  sticky: a completed word was dropped
//   parity_err   out  even-parity failure of the word in par_out
// -----------------------------------------------------------------------------
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no frame in progress; only a frame_start bit is accepted
// ST_SHIFT  | collecting data bits 1..WIDTH-1 of the current frame
// ST_PARITY | all data bits held, waiting for the parity bit (parity build)
// -----------------------------------------------------------------------------

module sipo_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    input  logic             shift_dir,
    input  logic             out_ready,
    output logic [WIDTH-1:0] par_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef SIPO_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [IW-1:0] MSB_IDX  = IW'(WIDTH - 1);
    localparam logic [IW-1:0] LSB_IDX  = '0;

    logic [1:0]       state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             dir_q;

    logic [1:0]       nxt_state;
    logic [CW-1:0]    nxt_cnt;
    logic [WIDTH-1:0] nxt_shift;
    logic             nxt_dir;
    logic             done;
    logic [WIDTH-1:0] done_word;
    logic             done_perr;
    logic [WIDTH-1:0] placed;
    logic [IW-1:0]    wr_idx;

    // -------------------------------------------------------------------------
    // Frame assembly
    // -------------------------------------------------------------------------
    always_comb begin
        nxt_state = state;
        nxt_cnt   = bit_cnt;
        nxt_shift = shift_reg;
        nxt_dir   = dir_q;
        done      = 1'b0;
        done_word = shift_reg;
        done_perr = 1'b0;

        // Data bit k of the frame lands at k (LSB first) or WIDTH-1-k (MSB
        // first). Only meaningful in ST_SHIFT, where bit_cnt is 1..WIDTH-1.
        wr_idx = dir_q ? (MSB_IDX - bit_cnt[IW-1:0]) : bit_cnt[IW-1:0];
        placed = shift_reg;

        if (bit_valid) begin
            if (frame_start) begin
                // Start or restart: any partial frame is silently discarded.
                nxt_state = ST_SHIFT;
                nxt_cnt   = CNT_ONE;
                nxt_dir   = shift_dir;
                nxt_shift = '0;
                nxt_shift[shift_dir ? MSB_IDX : LSB_IDX] = serial_in;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        placed[wr_idx] = serial_in;
                        if (bit_cnt == CNT_LAST) begin
`ifdef SIPO_PARITY_EN
                            nxt_state = ST_PARITY;
                            nxt_cnt   = bit_cnt + 1'b1;
                            nxt_shift = placed;
`else
                            done      = 1'b1;
                            done_word = placed;
                            nxt_state = ST_IDLE;
                            nxt_cnt   = '0;
                            nxt_shift = '0;
`endif
                        end else begin
                            nxt_cnt   = bit_cnt + 1'b1;
                            nxt_shift = placed;
                        end
                    end
`ifdef SIPO_PARITY_EN
                    ST_PARITY: begin
                        // Even parity: data bits plus parity bit must XOR to 0.
                        done      = 1'b1;
                        done_word = shift_reg;
                        done_perr = (^shift_reg) ^ serial_in;
                        nxt_state = ST_IDLE;
                        nxt_cnt   = '0;
                        nxt_shift = '0;
                    end
`endif
                    default: begin
                        // Idle bits without frame_start are dropped; an
                        // unreachable encoding falls back to idle.
                        nxt_state = ST_IDLE;
                        nxt_cnt   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            dir_q     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt_state;
            bit_cnt   <= nxt_cnt;
            shift_reg <= nxt_shift;
            dir_q     <= nxt_dir;
            busy      <= (nxt_state != ST_IDLE);
        end
    end

    // -------------------------------------------------------------------------
    // Output word and handshake
    // -------------------------------------------------------------------------
    // A word completing in the same edge as the pending one is accepted
    // replaces it and keeps out_valid high. If the pending word is not being
    // accepted, the new word is dropped and overrun latches until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_out    <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (done) begin
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end else begin
                    par_out    <= done_word;
                    parity_err <= done_perr;
                    out_valid  <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

    localparam int WIDTH = 8;
`ifdef SIPO_PARITY_EN
    localparam int FLEN   = WIDTH + 1;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int FLEN   = WIDTH;
    localparam bit PAR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             serial_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic             shift_dir = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] par_out;
    logic             out_valid;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    int checks = 0;
    int errors = 0;

    sipo_deserializer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .shift_dir   (shift_dir),
        .out_ready   (out_ready),
        .par_out     (par_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: the frame is a list of received bits; the word is
    // rebuilt from that list with plain arithmetic when the list is full.
    // ------------------------------------------------------------------
    bit               m_bits[$];
    bit               m_active;
    bit               m_dir;
    bit               m_valid;
    bit [WIDTH-1:0]   m_par;
    bit               m_perr;
    bit               m_ovr;

    function automatic void model_reset();
        m_bits.delete();
        m_active = 0;
        m_dir    = 0;
        m_valid  = 0;
        m_par    = '0;
        m_perr   = 0;
        m_ovr    = 0;
    endfunction

    function automatic void model_edge(bit bv, bit fs, bit si, bit dir, bit rdy);
        bit             fin = 0;
        int unsigned    word = 0;
        bit             px = 0;
        if (bv && fs) begin
            m_bits.delete();
            m_bits.push_back(si);
            m_dir    = dir;
            m_active = 1;
        end else if (bv && m_active) begin
            m_bits.push_back(si);
            if (m_bits.size() == FLEN) begin
                fin = 1;
                for (int k = 0; k < WIDTH; k++)
                    if (m_bits[k])
                        word += m_dir ? (32'd1 << (WIDTH - 1 - k)) : (32'd1 << k);
                for (int k = 0; k < FLEN; k++) px ^= m_bits[k];
                if (FLEN == WIDTH) px = 0;
                m_active = 0;
                m_bits.delete();
            end
        end
        if (fin) begin
            if (m_valid && !rdy) m_ovr = 1;
            else begin
                m_par   = word[WIDTH-1:0];
                m_perr  = px;
                m_valid = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("par_out",    32'(par_out),    32'(m_par));
        chk("out_valid",  32'(out_valid),  32'(m_valid));
        chk("busy",       32'(busy),       32'(m_active));
        chk("overrun",    32'(overrun),    32'(m_ovr));
        chk("parity_err", 32'(parity_err), 32'(m_perr));
    endtask

    task automatic drive(input bit bv, input bit fs, input bit si, input bit dir, input bit rdy);
        bit_valid   = bv;
        frame_start = fs;
        serial_in   = si;
        shift_dir   = dir;
        out_ready   = rdy;
    endtask

    // One clock: model follows the inputs held across the edge, then outputs
    // are compared 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        model_edge(bit_valid, frame_start, serial_in, shift_dir, out_ready);
        #1;
        chk_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #2;
        chk("rst_par_out",    32'(par_out),    32'h0);
        chk("rst_out_valid",  32'(out_valid),  32'h0);
        chk("rst_busy",       32'(busy),       32'h0);
        chk("rst_overrun",    32'(overrun),    32'h0);
        chk("rst_parity_err", 32'(parity_err), 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Sends one frame; seq[k] is the k-th bit on the wire. shift_dir is
    // randomized on every bit after bit 0 since only bit 0 samples it.
    task automatic send_frame(input bit dir, input bit [WIDTH-1:0] seq, input bit pbit,
                              input int gap, input bit rdy);
        for (int k = 0; k < FLEN; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    drive(0, 0, 1'($urandom), 1'($urandom), rdy);
                    step();
                end
            end
            drive(1, k == 0, (k < WIDTH) ? seq[k] : pbit, (k == 0) ? dir : 1'($urandom), rdy);
            step();
        end
        drive(0, 0, 0, 0, rdy);
    endtask

    typedef struct {
        bit             dir;
        bit [WIDTH-1:0] seq;
        bit             pbit;
        int             gap;
        bit [WIDTH-1:0] exp_par;
        bit             exp_perr_p;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 8'h1B, 0, 0, 8'h1B, 0};
        vecs[1] = '{1, 8'h1B, 0, 0, 8'hD8, 0};
        vecs[2] = '{0, 8'h1B, 1, 0, 8'h1B, 1};
        vecs[3] = '{0, 8'hA5, 1, 2, 8'hA5, 1};
        vecs[4] = '{1, 8'h01, 1, 1, 8'h80, 0};
        vecs[5] = '{1, 8'hF0, 0, 3, 8'h0F, 0};
        vecs[6] = '{0, 8'h1B, 1, 3, 8'h1B, 1};
        vecs[7] = '{1, 8'h07, 0, 0, 8'hE0, 1};

        model_reset();
        #3;
        do_reset();

        // Table-driven frames with out_ready=1: word appears, pulses one cycle.
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].dir, vecs[i].seq, vecs[i].pbit, vecs[i].gap, 1'b1);
            chk($sformatf("vec%0d_par_out", i), 32'(par_out), 32'(vecs[i].exp_par));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'h1);
            chk($sformatf("vec%0d_perr", i), 32'(parity_err),
                32'(PAR_EN ? vecs[i].exp_perr_p : 1'b0));
            step();
            chk($sformatf("vec%0d_valid_pulse", i), 32'(out_valid), 32'h0);
            chk($sformatf("vec%0d_par_hold", i), 32'(par_out), 32'(vecs[i].exp_par));
        end

        // Overrun: two frames with out_ready=0, second is dropped.
        do_reset();
        send_frame(0, 8'h1B, 0, 0, 1'b0);
        send_frame(0, 8'h55, 0, 0, 1'b0);
        chk("ovr_par_out", 32'(par_out), 32'h1B);
        chk("ovr_valid",   32'(out_valid), 32'h1);
        chk("ovr_flag",    32'(overrun), 32'h1);
        drive(0, 0, 0, 0, 1);
        step();
        chk("ovr_consume_valid", 32'(out_valid), 32'h0);
        chk("ovr_sticky",        32'(overrun), 32'h1);

        // Abort after 3 bits, restart with 0x0F: one word, no overrun.
        do_reset();
        drive(1, 1, 1, 0, 1); step();
        drive(1, 0, 0, 0, 1); step();
        drive(1, 0, 1, 0, 1); step();
        chk("abort_no_word", 32'(out_valid), 32'h0);
        send_frame(0, 8'h0F, 0, 0, 1'b1);
        chk("abort_par_out", 32'(par_out), 32'h0F);
        chk("abort_valid",   32'(out_valid), 32'h1);
        chk("abort_overrun", 32'(overrun), 32'h0);

        // Reset in the middle of a frame, then a clean frame 0xA5.
        drive(1, 1, 1, 0, 1); step();
        for (int k = 1; k < 5; k++) begin
            drive(1, 0, 1'($urandom), 0, 1); step();
        end
        drive(1, 0, 1, 0, 1);
        do_reset();
        for (int k = 0; k < 12; k++) begin
            drive(1, 0, 1'($urandom), 0, 1); step();
            chk("rst_no_spurious", 32'(out_valid), 32'h0);
        end
        send_frame(0, 8'hA5, 0, 0, 1'b1);
        chk("rst_par_out_a5", 32'(par_out), 32'hA5);
        chk("rst_valid_a5",   32'(out_valid), 32'h1);

        // Back-to-back completion with a word pending and being accepted.
        do_reset();
        send_frame(0, 8'h3C, 0, 0, 1'b0);
        drive(1, 1, 1, 0, 0); step();
        for (int k = 1; k < FLEN - 1; k++) begin
            drive(1, 0, 0, 0, 0); step();
        end
        drive(1, 0, 0, 0, 1); step();
        chk("b2b_valid",   32'(out_valid), 32'h1);
        chk("b2b_par_out", 32'(par_out), 32'h01);
        chk("b2b_overrun", 32'(overrun), 32'h0);

        // Randomized traffic against the model.
        for (int r = 0; r < 2; r++) begin
            drive(0, 0, 0, 0, 0);
            do_reset();
            for (int c = 0; c < 1500; c++) begin
                drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 14) == 0),
                      1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per frame (legal range 2..32).
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 serial_in  input  1  serial data bit, sampled only when bit_valid=1.
REQ-005 bit_valid  input  1  qualifies serial_in for one clk cycle.
REQ-006 frame_start  input  1  marks the bit presented in the same cycle as bit 0 of a new frame; ignored unless bit_valid=1.
REQ-007 shift_dir  input  1  bit order: 0 = LSB first, 1 = MSB first; sampled with bit 0 and held for the frame.
REQ-008 out_ready  input  1  downstream accepts par_out when out_valid=1.
REQ-009 par_out  output  WIDTH  assembled word.
REQ-010 out_valid  output  1  par_out holds an unconsumed word.
REQ-011 busy  output  1  frame in progress (state SHIFT or PARITY).
REQ-012 overrun  output  1  sticky: a completed word was dropped.
REQ-013 parity_err  output  1  even-parity failure of the word in par_out.

Function
REQ-014 FSM states IDLE, SHIFT, PARITY; all outputs registered.
REQ-015 IDLE -> SHIFT on bit_valid=1 and frame_start=1; that bit is bit 0, bit counter set to 1.
REQ-016 In IDLE, bit_valid=1 with frame_start=0 is discarded.
REQ-017 In SHIFT, each bit_valid=1 bit is stored and the counter increments; cycles with bit_valid=0 hold all state.
REQ-018 shift_dir=0: bit k lands at shift register index k; shift_dir=1: bit k lands at index WIDTH-1-k.
REQ-019 frame_start=1 with bit_valid=1 in SHIFT or PARITY aborts the partial frame and restarts with that bit as bit 0; no word emitted, overrun unchanged.
REQ-020 Word completion occurs on the edge sampling the last frame bit; out_valid rises and par_out updates on that same edge (visible the following cycle); FSM returns to IDLE.
REQ-021 Handshake: out_valid=1 and out_ready=1 at an edge consumes the word; out_valid clears unless a new word completes on the same edge.
REQ-022 Completion while out_valid=1 and out_ready=0: new word dropped, par_out unchanged, overrun set.
REQ-023 Completion while out_valid=1 and out_ready=1: new word loaded, out_valid stays 1, no overrun.
REQ-024 overrun clears only on reset.
REQ-025 busy=1 exactly while state is SHIFT or PARITY.
REQ-026 par_out holds its value while out_valid=0.

Reset
REQ-027 Asserting reset at any time, including mid-frame, forces IDLE, counter 0, shift register 0, par_out 0, out_valid 0, busy 0, overrun 0, parity_err 0.
REQ-028 First frame after deassertion requires frame_start; partial pre-reset bits are lost.

Configuration
REQ-029 Macro SIPO_PARITY_EN defined: after WIDTH data bits FSM enters PARITY; next bit_valid bit is the even-parity bit; completion on that edge, parity_err = XOR of data bits and parity bit, loaded with par_out.
REQ-030 SIPO_PARITY_EN undefined: no PARITY state, frame is WIDTH bits, parity_err tied to 0; port list unchanged.

Verification (WIDTH=8)
REQ-031 shift_dir=0, bits 1,1,0,1,1,0,0,0 (frame_start on first), out_ready=1 -> par_out=0x1B, out_valid pulses one cycle.
REQ-032 shift_dir=1, same bit sequence -> par_out=0xD8.
REQ-033 out_ready=0, two frames 0x1B then 0x55 -> par_out stays 0x1B, out_valid=1, overrun=1; raise out_ready -> out_valid clears next edge.
REQ-034 frame_start after 3 bits of a frame, then 8 bits of 0x0F LSB-first -> single word 0x0F, no overrun.
REQ-035 reset asserted after 5 bits, deasserted, full frame 0xA5 -> par_out=0xA5, no spurious word earlier.
REQ-036 SIPO_PARITY_EN: 0x1B with parity bit 0 -> parity_err=0; with parity bit 1 -> parity_err=1; bit_valid gaps between bits leave results unchanged.
